// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : prog_loader
// Purpose  : Streams a length-prefixed byte image into 9-bit instruction memory.
// Revision : 1.0 - initial release
// ============================================================================
module prog_loader #(
   parameter int D = 12
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          Start,
   input  logic [7:0]    RxData,
   input  logic          RxValid,
   output logic          RxReady,
   output logic          WrEn,
   output logic [D-1:0]  WrAddr,
   output logic [8:0]    WrData,
   output logic          Busy,
   output logic          Done,
   output logic          Error
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LEN_LO = 3'd1,
      S_LEN_HI = 3'd2,
      S_INS_LO = 3'd3,
      S_INS_HI = 3'd4,
      S_FIN    = 3'd5
   } state_t;

   localparam logic [31:0] c_max_words = 32'(1) << D;

   state_t        r_state;
   logic [7:0]    r_len_lo;
   logic [7:0]    r_ins_lo;
   logic [15:0]   r_remain;
   logic [D-1:0]  r_addr;

   logic          w_accept;
   logic [15:0]   w_len;

   always_comb begin
      RxReady = 1'b0;
      case (r_state)
         S_LEN_LO, S_LEN_HI, S_INS_LO, S_INS_HI: RxReady = 1'b1;
         default:                                RxReady = 1'b0;
      endcase
   end

   assign Busy     = (r_state != S_IDLE);
   assign w_accept = RxValid && RxReady;
   assign w_len    = {RxData, r_len_lo};

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state  <= S_IDLE;
         r_len_lo <= 8'd0;
         r_ins_lo <= 8'd0;
         r_remain <= 16'd0;
         r_addr   <= '0;
         WrEn     <= 1'b0;
         WrAddr   <= '0;
         WrData   <= 9'd0;
         Done     <= 1'b0;
         Error    <= 1'b0;
      end else begin
         WrEn <= 1'b0;
         Done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (Start) begin
                  Error   <= 1'b0;
                  r_addr  <= '0;
                  r_state <= S_LEN_LO;
               end
            end
            S_LEN_LO: begin
               if (w_accept) begin
                  r_len_lo <= RxData;
                  r_state  <= S_LEN_HI;
               end
            end
            S_LEN_HI: begin
               if (w_accept) begin
                  r_remain <= w_len;
                  if (w_len == 16'd0) begin
                     r_state <= S_FIN;
                  end else if ({16'd0, w_len} > c_max_words) begin
                     // Oversized image: drop back to idle without touching memory.
                     Error   <= 1'b1;
                     r_state <= S_IDLE;
                  end else begin
                     r_state <= S_INS_LO;
                  end
               end
            end
            S_INS_LO: begin
               if (w_accept) begin
                  r_ins_lo <= RxData;
                  r_state  <= S_INS_HI;
               end
            end
            S_INS_HI: begin
               if (w_accept) begin
                  WrEn     <= 1'b1;
                  WrData   <= {RxData[0], r_ins_lo};
                  WrAddr   <= r_addr;
                  r_addr   <= r_addr + D'(1);
                  r_remain <= r_remain - 16'd1;
                  r_state  <= (r_remain == 16'd1) ? S_FIN : S_INS_LO;
               end
            end
            S_FIN: begin
               // Done lands the cycle after the last write strobe.
               Done    <= 1'b1;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_prog_loader
// Purpose  : Randomized self-checking bench for prog_loader against a stream model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prog_loader;

   localparam int D = 12;

   logic          Clk = 1'b0;
   logic          Reset = 1'b1;
   logic          Start = 1'b0;
   logic [7:0]    RxData = 8'd0;
   logic          RxValid = 1'b0;
   logic          RxReady;
   logic          WrEn;
   logic [D-1:0]  WrAddr;
   logic [8:0]    WrData;
   logic          Busy;
   logic          Done;
   logic          Error;

   prog_loader #(.D(D)) dut (
      .Clk     (Clk),
      .Reset   (Reset),
      .Start   (Start),
      .RxData  (RxData),
      .RxValid (RxValid),
      .RxReady (RxReady),
      .WrEn    (WrEn),
      .WrAddr  (WrAddr),
      .WrData  (WrData),
      .Busy    (Busy),
      .Done    (Done),
      .Error   (Error)
   );

   always #5 Clk = ~Clk;

   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   int          acc_cyc = 0;
   int          done_cnt = 0;
   int          done_cyc = -1;
   logic [7:0]  stim[$];
   logic [20:0] got_wr[$];
   logic [20:0] exp_wr[$];

   always @(posedge Clk) cyc <= cyc + 1;

   always @(negedge Clk) begin
      if (WrEn) got_wr.push_back({WrAddr, WrData});
      if (Done) begin
         done_cnt = done_cnt + 1;
         done_cyc = cyc;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks = checks + 1;
      if (got !== exp) begin
         failures = failures + 1;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input bit jitter, input bit snoise);
      logic rdy;
      RxData = b;
      for (int g = 0; g < 64; g++) begin
         if (snoise) Start = 1'($urandom_range(0, 1));
         if (jitter && $urandom_range(0, 2) == 0) begin
            RxValid = 1'b0;
            @(posedge Clk); #1;
            check("rxready_hold", {31'd0, RxReady}, 32'd1);
         end else begin
            RxValid = 1'b1;
            rdy = RxReady;
            @(posedge Clk); #1;
            if (rdy) begin
               acc_cyc = cyc;
               Start = 1'b0;
               return;
            end
         end
      end
      Start = 1'b0;
      check("accept_timeout", 32'd0, 32'd1);
   endtask

   // Reference: header is a little-endian word count; each word is lo byte plus bit0 of hi byte.
   task automatic run_load(input bit jitter, input bit snoise);
      int  n;
      bit  exp_err;
      n = {24'd0, stim[0]} + ({24'd0, stim[1]} << 8);
      exp_err = (n > (1 << D));
      exp_wr.delete();
      if (!exp_err)
         for (int i = 0; i < n; i++)
            exp_wr.push_back({12'(i), stim[3 + 2*i][0], stim[2 + 2*i]});
      got_wr.delete();
      done_cnt = 0;
      done_cyc = -1;

      Start = 1'b1;
      @(posedge Clk); #1;
      Start = 1'b0;
      check("err_clr", {31'd0, Error}, 32'd0);
      check("busy_start", {31'd0, Busy}, 32'd1);
      foreach (stim[k]) send_byte(stim[k], jitter, snoise);
      RxValid = 1'b0;
      repeat (3) @(posedge Clk);
      #1;

      check("nwr", got_wr.size(), exp_wr.size());
      for (int i = 0; i < got_wr.size() && i < exp_wr.size(); i++)
         check("wr", {11'd0, got_wr[i]}, {11'd0, exp_wr[i]});
      check("done_cnt", done_cnt, exp_err ? 32'd0 : 32'd1);
      if (!exp_err) check("done_lat", done_cyc, acc_cyc + 1);
      check("error", {31'd0, Error}, {31'd0, exp_err});
      check("busy_end", {31'd0, Busy}, 32'd0);
      if (!exp_err && n > 0) check("hold_wr", {11'd0, WrAddr, WrData}, {11'd0, exp_wr[$]});
   endtask

   task automatic make_stim(input int n);
      stim.delete();
      stim.push_back(n[7:0]);
      stim.push_back(n[15:8]);
      for (int i = 0; i < 2*n; i++) stim.push_back(8'($urandom));
   endtask

   initial begin
      repeat (3) @(posedge Clk);
      #1;
      Reset = 1'b0;
      check("rst_wren",  {31'd0, WrEn},    32'd0);
      check("rst_addr",  {20'd0, WrAddr},  32'd0);
      check("rst_data",  {23'd0, WrData},  32'd0);
      check("rst_done",  {31'd0, Done},    32'd0);
      check("rst_error", {31'd0, Error},   32'd0);
      check("rst_busy",  {31'd0, Busy},    32'd0);
      check("rst_ready", {31'd0, RxReady}, 32'd0);

      stim = '{8'h03, 8'h00, 8'hFE, 8'h00, 8'h66, 8'h01, 8'h7A, 8'h00};
      run_load(1'b0, 1'b0);

      stim = '{8'h00, 8'h00};
      run_load(1'b0, 1'b0);

      stim = '{8'h01, 8'h10};
      run_load(1'b0, 1'b0);

      stim = '{8'h02, 8'h00, 8'hFF, 8'hFF, 8'h01, 8'h00};
      run_load(1'b1, 1'b0);

      stim = '{8'h02, 8'h00, 8'h34, 8'hFE, 8'hC1, 8'h03};
      run_load(1'b1, 1'b1);

      make_stim(1);
      run_load(1'b0, 1'b0);

      for (int r = 0; r < 6; r++) begin
         make_stim($urandom_range(1, 12));
         run_load(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      make_stim(1 << D);
      run_load(1'b0, 1'b0);

      // Reset after the first word of a 3-word load.
      got_wr.delete();
      done_cnt = 0;
      Start = 1'b1;
      @(posedge Clk); #1;
      Start = 1'b0;
      stim = '{8'h03, 8'h00, 8'hAA, 8'h01};
      foreach (stim[k]) send_byte(stim[k], 1'b0, 1'b0);
      Reset = 1'b1;
      @(posedge Clk); #1;
      Reset = 1'b0;
      check("mid_wren",  {31'd0, WrEn},    32'd0);
      check("mid_addr",  {20'd0, WrAddr},  32'd0);
      check("mid_data",  {23'd0, WrData},  32'd0);
      check("mid_busy",  {31'd0, Busy},    32'd0);
      check("mid_ready", {31'd0, RxReady}, 32'd0);
      RxValid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         RxData = 8'($urandom);
         @(posedge Clk); #1;
      end
      RxValid = 1'b0;
      check("mid_nwr",  got_wr.size(), 32'd1);
      check("mid_word", {11'd0, got_wr[0]}, {11'd0, 12'd0, 9'h1AA});
      check("mid_done", done_cnt, 32'd0);
      check("mid_idle", {31'd0, Busy}, 32'd0);

      make_stim(2);
      run_load(1'b1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
